// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes,
// immediate formats and datapath select codes.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'b00,
        ALU_OP_SUB   = 2'b01,
        ALU_OP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Immediate formats; the sign extender decodes these same values.
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    function automatic logic [1:0] imm_src_for(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Control-unit <-> datapath bundle: instruction fields and flags in,
// mux selects and write enables out.
interface mc_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [2:0] alu_control;
    logic       illegal;

    modport master (
        input  op, funct3, funct7b5, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, imm_src, alu_control, illegal
    );

    modport slave (
        output op, funct3, funct7b5, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, imm_src, alu_control, illegal
    );
endinterface

// File: rtl/alu_decoder.sv
// Maps the FSM's ALU request plus instruction funct bits onto an ALU operation.
import mc_ctrl_pkg::*;

module alu_decoder (
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALU_OP_ADD: alu_control = ALU_ADD;
            ALU_OP_SUB: alu_control = ALU_SUB;
            ALU_OP_FUNCT: begin
                case (funct3)
                    // funct7b5 only means sub for register-register ops; addi ignores it
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end
endmodule

// File: rtl/mc_controller.sv
// Multicycle RV32I control FSM; only the state is registered, all datapath
// controls decode combinationally from state, opcode and handshake inputs.
//
// state      | meaning
// FETCH      | read instr at PC, PC += 4 when memory ready
// DECODE     | branch target into ALUOut, dispatch on opcode
// MEMADR     | rs1 + imm address into ALUOut
// MEMREAD    | load access at ALUOut, wait for ready
// MEMWB      | write loaded data to rd
// MEMWRITE   | store access at ALUOut, wait for ready
// EXECUTER   | register-register ALU op
// EXECUTEI   | register-immediate ALU op
// ALUWB      | write ALUOut to rd
// BEQ        | compare rs1/rs2, take branch on zero
// JAL        | PC <- target, oldPC + 4 into ALUOut
import mc_ctrl_pkg::*;

module mc_controller (
    input logic               clk,
    input logic               rst,
    mc_controller_if.master   bus
);
    state_t     state;
    state_t     next_state;
    alu_op_t    alu_op;
    logic [2:0] alu_control;

    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= next_state;
    end

    always_comb begin
        next_state         = state;
        alu_op             = ALU_OP_ADD;
        bus.pc_write       = 1'b0;
        bus.adr_src        = 1'b0;
        bus.mem_write      = 1'b0;
        bus.ir_write       = 1'b0;
        bus.reg_write      = 1'b0;
        bus.result_src     = RES_ALUOUT;
        bus.alu_src_a      = SRCA_PC;
        bus.alu_src_b      = SRCB_RS2;
        bus.illegal        = 1'b0;
        case (state)
            S_FETCH: begin
                bus.result_src = RES_ALURESULT;
                bus.alu_src_b  = SRCB_FOUR;
                bus.ir_write   = bus.mem_ready;
                bus.pc_write   = bus.mem_ready;
                if (bus.mem_ready) next_state = S_DECODE;
            end
            S_DECODE: begin
                bus.alu_src_a = SRCA_OLDPC;
                bus.alu_src_b = SRCB_IMM;
                case (bus.op)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_RTYPE:          next_state = S_EXECUTER;
                    OP_ITYPE:          next_state = S_EXECUTEI;
                    OP_BRANCH:         next_state = S_BEQ;
                    OP_JAL:            next_state = S_JAL;
                    default: begin
                        bus.illegal = 1'b1;
                        next_state  = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_src_b = SRCB_IMM;
                next_state    = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                bus.adr_src = 1'b1;
                if (bus.mem_ready) next_state = S_MEMWB;
            end
            S_MEMWB: begin
                bus.result_src = RES_DATA;
                bus.reg_write  = 1'b1;
                next_state     = S_FETCH;
            end
            S_MEMWRITE: begin
                bus.adr_src   = 1'b1;
                bus.mem_write = 1'b1;
                if (bus.mem_ready) next_state = S_FETCH;
            end
            S_EXECUTER: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_src_b = SRCB_RS2;
                alu_op        = ALU_OP_FUNCT;
                next_state    = S_ALUWB;
            end
            S_EXECUTEI: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_src_b = SRCB_IMM;
                alu_op        = ALU_OP_FUNCT;
                next_state    = S_ALUWB;
            end
            S_ALUWB: begin
                bus.result_src = RES_ALUOUT;
                bus.reg_write  = 1'b1;
                next_state     = S_FETCH;
            end
            S_BEQ: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_src_b = SRCB_RS2;
                alu_op        = ALU_OP_SUB;
                bus.pc_write  = bus.zero;
                next_state    = S_FETCH;
            end
            S_JAL: begin
                bus.alu_src_a = SRCA_OLDPC;
                bus.alu_src_b = SRCB_FOUR;
                bus.pc_write  = 1'b1;
                next_state    = S_ALUWB;
            end
            default: next_state = S_FETCH;
        endcase
        // Reset must silence every side effect immediately, even mid-access.
        if (rst) begin
            bus.pc_write  = 1'b0;
            bus.ir_write  = 1'b0;
            bus.mem_write = 1'b0;
            bus.reg_write = 1'b0;
            bus.illegal   = 1'b0;
        end
    end

    assign bus.imm_src     = imm_src_for(bus.op);
    assign bus.alu_control = alu_control;

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (bus.funct3),
        .funct7b5    (bus.funct7b5),
        .op5         (bus.op[5]),
        .alu_control (alu_control)
    );
endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: each stimulus cycle queues the expected
// control vector; a negedge monitor pops and compares it against the outputs.
module tb_mc_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mc_controller_if bus ();
    mc_controller dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        string       name;
        logic [16:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
    //  alu_src_a, alu_src_b, imm_src, alu_control, illegal}
    function automatic logic [16:0] e(input logic pcw, adr, mw, irw, rw,
                                      input logic [1:0] rs, a, b, imm,
                                      input logic [2:0] alu, input logic ill);
        return {pcw, adr, mw, irw, rw, rs, a, b, imm, alu, ill};
    endfunction

    wire [16:0] act = {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write,
                       bus.reg_write, bus.result_src, bus.alu_src_a, bus.alu_src_b,
                       bus.imm_src, bus.alu_control, bus.illegal};

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t x;
                x = exp_q.pop_front();
                checks++;
                if (act !== x.v) begin
                    errors++;
                    $display("FAIL %s got %b expected %b", x.name, act, x.v);
                end
            end
        end
    end

    task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        bus.op       = o;
        bus.funct3   = f3;
        bus.funct7b5 = f7;
    endtask

    task automatic step(input string name, input logic z, input logic mr,
                        input logic r, input logic [16:0] v);
        exp_t x;
        bus.zero      = z;
        bus.mem_ready = mr;
        rst           = r;
        x.name        = name;
        x.v           = v;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        instr(7'b0000011, 3'b010, 1'b0);
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        step("reset_fetch", 0, 1, 1, e(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));

        // lw, zero wait: 5 cycles
        step("lw_fetch",   0, 1, 0, e(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        step("lw_decode",  0, 1, 0, e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
        step("lw_memadr",  0, 1, 0, e(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0));
        step("lw_memread", 0, 1, 0, e(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0));
        step("lw_memwb",   0, 1, 0, e(0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,3'b000,0));

        // sw with three wait cycles in MEMWRITE
        instr(7'b0100011, 3'b010, 1'b0);
        step("sw_fetch",   0, 1, 0, e(1,0,0,1,0,2'b10,2'b00,2'b10,2'b01,3'b000,0));
        step("sw_decode",  0, 1, 0, e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b000,0));
        step("sw_memadr",  0, 1, 0, e(0,0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000,0));
        for (int i = 0; i < 3; i++)
            step("sw_wait", 0, 0, 0, e(0,1,1,0,0,2'b00,2'b00,2'b00,2'b01,3'b000,0));
        step("sw_done",    0, 1, 0, e(0,1,1,0,0,2'b00,2'b00,2'b00,2'b01,3'b000,0));

        // R-type sub with one fetch wait
        instr(7'b0110011, 3'b000, 1'b1);
        step("sub_fetch_wait", 0, 0, 0, e(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        step("sub_fetch",  0, 1, 0, e(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        step("sub_decode", 0, 1, 0, e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
        step("sub_exec",   0, 1, 0, e(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b001,0));
        step("sub_aluwb",  0, 1, 0, e(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0));

        // addi with funct7b5 set still adds
        instr(7'b0010011, 3'b000, 1'b1);
        step("addi_fetch", 0, 1, 0, e(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        step("addi_decode",0, 1, 0, e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
        step("addi_exec",  0, 1, 0, e(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0));
        step("addi_aluwb", 0, 1, 0, e(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0));

        // slti, R-type and, ori: only the execute cycle differs
        instr(7'b0010011, 3'b010, 1'b0);
        step("slti_fetch", 0, 1, 0, e(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        step("slti_decode",0, 1, 0, e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
        step("slti_exec",  0, 1, 0, e(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b101,0));
        step("slti_aluwb", 0, 1, 0, e(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0));
        instr(7'b0110011, 3'b111, 1'b0);
        step("and_fetch",  0, 1, 0, e(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        step("and_decode", 0, 1, 0, e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
        step("and_exec",   0, 1, 0, e(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b010,0));
        step("and_aluwb",  0, 1, 0, e(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0));
        instr(7'b0010011, 3'b110, 1'b0);
        step("ori_fetch",  0, 1, 0, e(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        step("ori_decode", 0, 1, 0, e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
        step("ori_exec",   0, 1, 0, e(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b011,0));
        step("ori_aluwb",  0, 1, 0, e(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0));

        // beq taken, then not taken; zero toggled outside BEQ must not matter
        instr(7'b1100011, 3'b000, 1'b0);
        step("beq1_fetch", 1, 1, 0, e(1,0,0,1,0,2'b10,2'b00,2'b10,2'b10,3'b000,0));
        step("beq1_decode",1, 1, 0, e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0));
        step("beq1_taken", 1, 1, 0, e(1,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,0));
        step("beq0_fetch", 1, 1, 0, e(1,0,0,1,0,2'b10,2'b00,2'b10,2'b10,3'b000,0));
        step("beq0_decode",1, 1, 0, e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0));
        step("beq0_nottkn",0, 1, 0, e(0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,0));

        // jal
        instr(7'b1101111, 3'b000, 1'b0);
        step("jal_fetch",  0, 1, 0, e(1,0,0,1,0,2'b10,2'b00,2'b10,2'b11,3'b000,0));
        step("jal_decode", 0, 1, 0, e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b11,3'b000,0));
        step("jal_jal",    0, 1, 0, e(1,0,0,0,0,2'b00,2'b01,2'b10,2'b11,3'b000,0));
        step("jal_aluwb",  0, 1, 0, e(0,0,0,0,1,2'b00,2'b00,2'b00,2'b11,3'b000,0));

        // illegal opcode: 2 cycles, single pulse
        instr(7'b1110011, 3'b000, 1'b0);
        step("ill_fetch",  0, 1, 0, e(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        step("ill_decode", 0, 1, 0, e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,1));

        // reset during MEMREAD: enables off that cycle, FETCH next
        instr(7'b0000011, 3'b010, 1'b0);
        step("rlw_fetch",  0, 1, 0, e(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        step("rlw_decode", 0, 1, 0, e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
        step("rlw_memadr", 0, 1, 0, e(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0));
        step("rlw_rst",    0, 1, 1, e(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0));

        // reset during MEMWRITE drops mem_write at once
        instr(7'b0100011, 3'b010, 1'b0);
        step("rsw_fetch",  0, 1, 0, e(1,0,0,1,0,2'b10,2'b00,2'b10,2'b01,3'b000,0));
        step("rsw_decode", 0, 1, 0, e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b000,0));
        step("rsw_memadr", 0, 0, 0, e(0,0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000,0));
        step("rsw_wait",   0, 0, 0, e(0,1,1,0,0,2'b00,2'b00,2'b00,2'b01,3'b000,0));
        step("rsw_rst",    0, 0, 1, e(0,1,0,0,0,2'b00,2'b00,2'b00,2'b01,3'b000,0));
        step("rsw_after",  0, 1, 0, e(1,0,0,1,0,2'b10,2'b00,2'b10,2'b01,3'b000,0));

        @(posedge clk);
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
